// File: rtl/ex_defs.sv
// Shared encodings for the ID/EX stage: opcode classes, ALU selects, memory ops
// and the decoded control bundle stored in each pipeline entry.
package ex_defs;

    localparam int CLS_W = 3;

    typedef enum logic [2:0] {
        CLS_NOP   = 3'd0,
        CLS_LOGIC = 3'd1,
        CLS_SHIFT = 3'd2,
        CLS_ARITH = 3'd3,
        CLS_MOVE  = 3'd4,
        CLS_LOAD  = 3'd5,
        CLS_STORE = 3'd6,
        CLS_JUMP  = 3'd7
    } cls_e;

    typedef enum logic [2:0] {
        ALU_NOP   = 3'd0,
        ALU_LOGIC = 3'd1,
        ALU_SHIFT = 3'd2,
        ALU_ARITH = 3'd3,
        ALU_MOVE  = 3'd4
    } alusel_e;

    typedef enum logic [2:0] {
        MEM_NOP       = 3'd0,
        MEM_WRITE_REG = 3'd1,
        MEM_LOAD      = 3'd2,
        MEM_STORE     = 3'd3
    } memop_e;

    typedef struct packed {
        alusel_e alusel;
        memop_e  memop;
        logic    write_enable;
    } dec_ctrl_t;

endpackage

// File: rtl/ex_op_decode.sv
// Combinational class decode: opcode class field to ALU select, memory op and
// write enable, with writes to register 0 suppressed.
import ex_defs::*;

module ex_op_decode #(
    parameter int HIGH_W     = 3,
    parameter int REG_ADDR_W = 5
) (
    input  logic [HIGH_W-1:0]     cls,
    input  logic [REG_ADDR_W-1:0] dest,
    output dec_ctrl_t             ctrl
);

    always_comb begin
        ctrl = '{alusel: ALU_NOP, memop: MEM_NOP, write_enable: 1'b0};
        // A wider class field with any bit set above the known codes is unknown.
        if ((cls >> CLS_W) == '0) begin
            case (cls_e'(cls[CLS_W-1:0]))
                CLS_LOGIC: ctrl = '{alusel: ALU_LOGIC, memop: MEM_WRITE_REG, write_enable: 1'b1};
                CLS_SHIFT: ctrl = '{alusel: ALU_SHIFT, memop: MEM_WRITE_REG, write_enable: 1'b1};
                CLS_ARITH: ctrl = '{alusel: ALU_ARITH, memop: MEM_WRITE_REG, write_enable: 1'b1};
                CLS_MOVE:  ctrl = '{alusel: ALU_MOVE,  memop: MEM_WRITE_REG, write_enable: 1'b1};
                CLS_LOAD:  ctrl = '{alusel: ALU_ARITH, memop: MEM_LOAD,      write_enable: 1'b1};
                CLS_STORE: ctrl = '{alusel: ALU_ARITH, memop: MEM_STORE,     write_enable: 1'b0};
                default:   ctrl = '{alusel: ALU_NOP,   memop: MEM_NOP,       write_enable: 1'b0};
            endcase
        end
        if (dest == '0) begin
            ctrl.write_enable = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: main entry drives execute, skid entry absorbs one input
// while execute stalls, flush kills both entries and the incoming instruction.
import ex_defs::*;

module id_ex_stage #(
    parameter int WORD_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int EX_OP_W     = 8,
    parameter int EX_OP_HIGH_W = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        id_valid,
    output logic                        id_ready,
    input  logic [EX_OP_W-1:0]          id_exop,
    input  logic [WORD_W-1:0]           id_srcl,
    input  logic [WORD_W-1:0]           id_srcr,
    input  logic [WORD_W-1:0]           id_offset,
    input  logic [REG_ADDR_W-1:0]       id_dest,
    output logic                        ex_valid,
    input  logic                        ex_ready,
    output logic [2:0]                  ex_alusel,
    output logic [EX_OP_W-EX_OP_HIGH_W-1:0] ex_aluop,
    output logic [WORD_W-1:0]           ex_srcl,
    output logic [WORD_W-1:0]           ex_srcr,
    output logic [WORD_W-1:0]           ex_offset,
    output logic [2:0]                  ex_memop,
    output logic [REG_ADDR_W-1:0]       ex_dest,
    output logic                        ex_writeEnable
);

    localparam int LOW_W = EX_OP_W - EX_OP_HIGH_W;

    typedef struct packed {
        dec_ctrl_t               ctrl;
        logic [LOW_W-1:0]        aluop;
        logic [WORD_W-1:0]       srcl;
        logic [WORD_W-1:0]       srcr;
        logic [WORD_W-1:0]       offset;
        logic [REG_ADDR_W-1:0]   dest;
    } entry_t;

    dec_ctrl_t in_ctrl;
    entry_t    in_entry;
    entry_t    main_entry;
    entry_t    skid_entry;
    logic      main_valid;
    logic      skid_valid;
    logic      in_xfer;
    logic      main_free;

    ex_op_decode #(
        .HIGH_W     (EX_OP_HIGH_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_decode (
        .cls  (id_exop[EX_OP_W-1 -: EX_OP_HIGH_W]),
        .dest (id_dest),
        .ctrl (in_ctrl)
    );

    always_comb begin
        in_entry        = '0;
        in_entry.ctrl   = in_ctrl;
        in_entry.aluop  = id_exop[LOW_W-1:0];
        in_entry.srcl   = id_srcl;
        in_entry.srcr   = id_srcr;
        in_entry.offset = id_offset;
        in_entry.dest   = id_dest;
    end

    // id_ready comes straight from the skid flop, so it never depends on ex_ready.
    assign id_ready  = !skid_valid;
    assign in_xfer   = id_valid && id_ready;
    assign main_free = !main_valid || ex_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_entry <= '0;
            skid_entry <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            // While the skid is full id_ready is low, so no input can compete here.
            if (skid_valid) begin
                main_entry <= skid_entry;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= in_xfer;
                if (in_xfer) begin
                    main_entry <= in_entry;
                end
            end
        end else if (in_xfer) begin
            skid_entry <= in_entry;
            skid_valid <= 1'b1;
        end
    end

    assign ex_valid       = main_valid;
    assign ex_alusel      = main_valid ? main_entry.ctrl.alusel : ALU_NOP;
    assign ex_memop       = main_valid ? main_entry.ctrl.memop  : MEM_NOP;
    assign ex_writeEnable = main_valid && main_entry.ctrl.write_enable;
    assign ex_aluop       = main_entry.aluop;
    assign ex_srcl        = main_entry.srcl;
    assign ex_srcr        = main_entry.srcr;
    assign ex_offset      = main_entry.offset;
    assign ex_dest        = main_entry.dest;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a two-deep in-order queue model with a decode table,
// checked every cycle, plus hand-computed expectations for directed scenarios.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [7:0]  id_exop;
    logic [31:0] id_srcl, id_srcr, id_offset;
    logic [4:0]  id_dest;
    logic        ex_valid;
    logic        ex_ready;
    logic [2:0]  ex_alusel;
    logic [4:0]  ex_aluop;
    logic [31:0] ex_srcl, ex_srcr, ex_offset;
    logic [2:0]  ex_memop;
    logic [4:0]  ex_dest;
    logic        ex_writeEnable;

    id_ex_stage #(
        .WORD_W(32), .REG_ADDR_W(5), .EX_OP_W(8), .EX_OP_HIGH_W(3)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_exop(id_exop),
        .id_srcl(id_srcl), .id_srcr(id_srcr), .id_offset(id_offset), .id_dest(id_dest),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alusel(ex_alusel), .ex_aluop(ex_aluop),
        .ex_srcl(ex_srcl), .ex_srcr(ex_srcr), .ex_offset(ex_offset),
        .ex_memop(ex_memop), .ex_dest(ex_dest), .ex_writeEnable(ex_writeEnable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  alusel;
        logic [4:0]  aluop;
        logic [31:0] srcl, srcr, offset;
        logic [2:0]  memop;
        logic [4:0]  dest;
        logic        we;
    } exp_t;

    // Class index: NOP LOGIC SHIFT ARITH MOVE LOAD STORE JUMP
    logic [2:0] tbl_alu [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd3, 3'd0};
    logic [2:0] tbl_mem [8] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd0};
    logic       tbl_we  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    exp_t exp_q[$];
    exp_t last_main;
    exp_t head;
    bit   live = 0;
    bit   rdy_m;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        e.alusel = tbl_alu[id_exop[7:5]];
        e.memop  = tbl_mem[id_exop[7:5]];
        e.we     = tbl_we[id_exop[7:5]] && (id_dest != 5'd0);
        e.aluop  = id_exop[4:0];
        e.srcl   = id_srcl;
        e.srcr   = id_srcr;
        e.offset = id_offset;
        e.dest   = id_dest;
        return e;
    endfunction

    // Model: the stage behaves as an in-order queue of at most two instructions.
    always @(posedge clk) begin
        live = 1;
        if (rst) begin
            exp_q.delete();
            last_main = '{default: 0};
        end else if (flush) begin
            exp_q.delete();
        end else begin
            rdy_m = exp_q.size() < 2;
            if (exp_q.size() > 0 && ex_ready) void'(exp_q.pop_front());
            if (id_valid && rdy_m) exp_q.push_back(predict());
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("ex_valid", ex_valid, exp_q.size() > 0);
            check("id_ready", id_ready, exp_q.size() < 2);
            if (exp_q.size() > 0) begin
                head = exp_q[0];
                last_main = head;
                check("alusel", ex_alusel, head.alusel);
                check("aluop", ex_aluop, head.aluop);
                check("memop", ex_memop, head.memop);
                check("we", ex_writeEnable, head.we);
                check("srcl", ex_srcl, head.srcl);
                check("srcr", ex_srcr, head.srcr);
                check("offset", ex_offset, head.offset);
                check("dest", ex_dest, head.dest);
            end else begin
                check("bubble_alusel", ex_alusel, 3'd0);
                check("bubble_memop", ex_memop, 3'd0);
                check("bubble_we", ex_writeEnable, 1'b0);
                check("hold_aluop", ex_aluop, last_main.aluop);
                check("hold_srcl", ex_srcl, last_main.srcl);
                check("hold_srcr", ex_srcr, last_main.srcr);
                check("hold_offset", ex_offset, last_main.offset);
                check("hold_dest", ex_dest, last_main.dest);
            end
        end
    end

    function automatic logic [7:0] mk(input logic [2:0] cls, input logic [4:0] low);
        return {cls, low};
    endfunction

    task automatic step(input logic v, input logic [7:0] op, input logic [31:0] l,
                        input logic [4:0] d, input logic er, input logic fl);
        id_valid  = v;
        id_exop   = op;
        id_srcl   = l;
        id_srcr   = l ^ 32'h5555_0000;
        id_offset = l + 32'd4;
        id_dest   = d;
        ex_ready  = er;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic er);
        step(1'b0, 8'h00, 32'h0, 5'd0, er, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle(1'b1);
        idle(1'b1);
        check("lit_reset_valid", ex_valid, 1'b0);
        check("lit_reset_ready", id_ready, 1'b1);
        check("lit_reset_srcl", ex_srcl, 32'h0);
        check("lit_reset_dest", ex_dest, 5'd0);
        rst = 1'b0;

        // Single LOGIC op
        step(1'b1, mk(3'd1, 5'h05), 32'h1234, 5'd3, 1'b1, 1'b0);
        check("lit_logic_valid", ex_valid, 1'b1);
        check("lit_logic_alusel", ex_alusel, 3'd1);
        check("lit_logic_aluop", ex_aluop, 5'h05);
        check("lit_logic_memop", ex_memop, 3'd1);
        check("lit_logic_we", ex_writeEnable, 1'b1);
        check("lit_logic_srcl", ex_srcl, 32'h1234);
        idle(1'b1);

        // Four-op stream with a three-cycle stall starting at op 2
        step(1'b1, mk(3'd2, 5'h01), 32'hA0, 5'd1, 1'b1, 1'b0);
        step(1'b1, mk(3'd3, 5'h02), 32'hB0, 5'd2, 1'b1, 1'b0);
        step(1'b1, mk(3'd4, 5'h03), 32'hC0, 5'd4, 1'b0, 1'b0);
        check("lit_stall_ready_low", id_ready, 1'b0);
        check("lit_stall_srcl0", ex_srcl, 32'hB0);
        step(1'b1, mk(3'd5, 5'h04), 32'hD0, 5'd5, 1'b0, 1'b0);
        check("lit_stall_srcl1", ex_srcl, 32'hB0);
        step(1'b1, mk(3'd5, 5'h04), 32'hD0, 5'd5, 1'b0, 1'b0);
        check("lit_stall_srcl2", ex_srcl, 32'hB0);
        step(1'b1, mk(3'd5, 5'h04), 32'hD0, 5'd5, 1'b1, 1'b0);
        check("lit_release_ready", id_ready, 1'b1);
        check("lit_release_srcl", ex_srcl, 32'hC0);
        step(1'b1, mk(3'd5, 5'h04), 32'hD0, 5'd5, 1'b1, 1'b0);
        check("lit_op4_srcl", ex_srcl, 32'hD0);
        check("lit_op4_memop", ex_memop, 3'd2);
        idle(1'b1);

        // STORE to r7, then ARITH to r0
        step(1'b1, mk(3'd6, 5'h0A), 32'h700, 5'd7, 1'b1, 1'b0);
        check("lit_store_memop", ex_memop, 3'd3);
        check("lit_store_we", ex_writeEnable, 1'b0);
        check("lit_store_alusel", ex_alusel, 3'd3);
        step(1'b1, mk(3'd3, 5'h0B), 32'h800, 5'd0, 1'b1, 1'b0);
        check("lit_arith_r0_we", ex_writeEnable, 1'b0);
        check("lit_arith_r0_memop", ex_memop, 3'd1);
        idle(1'b1);

        // Skid full, then flush with a live input
        step(1'b1, mk(3'd1, 5'h11), 32'hE0, 5'd8, 1'b0, 1'b0);
        step(1'b1, mk(3'd2, 5'h12), 32'hF0, 5'd9, 1'b0, 1'b0);
        step(1'b1, mk(3'd3, 5'h13), 32'h1F0, 5'd10, 1'b0, 1'b1);
        check("lit_flush_valid", ex_valid, 1'b0);
        check("lit_flush_ready", id_ready, 1'b1);
        check("lit_flush_alusel", ex_alusel, 3'd0);
        idle(1'b1);
        check("lit_flush_no_ghost", ex_valid, 1'b0);
        // Flush while empty and ready: the offered input is still dropped
        step(1'b1, mk(3'd1, 5'h14), 32'h2F0, 5'd11, 1'b1, 1'b1);
        check("lit_flush_drop", ex_valid, 1'b0);
        // Flush together with an output transfer
        step(1'b1, mk(3'd4, 5'h15), 32'h3F0, 5'd12, 1'b0, 1'b0);
        step(1'b0, 8'h00, 32'h0, 5'd0, 1'b1, 1'b1);
        idle(1'b1);

        // Reset with both entries held
        step(1'b1, mk(3'd1, 5'h16), 32'h4F0, 5'd13, 1'b0, 1'b0);
        step(1'b1, mk(3'd2, 5'h17), 32'h5F0, 5'd14, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1, mk(3'd3, 5'h18), 32'h6F0, 5'd15, 1'b0, 1'b0);
        rst = 1'b0;
        check("lit_rst_valid", ex_valid, 1'b0);
        check("lit_rst_ready", id_ready, 1'b1);
        check("lit_rst_srcl", ex_srcl, 32'h0);
        check("lit_rst_aluop", ex_aluop, 5'd0);
        check("lit_rst_dest", ex_dest, 5'd0);

        // JUMP and NOP classes decode to a no-op that is still valid
        step(1'b1, mk(3'd7, 5'h1F), 32'h7F0, 5'd6, 1'b1, 1'b0);
        check("lit_jump_valid", ex_valid, 1'b1);
        check("lit_jump_alusel", ex_alusel, 3'd0);
        check("lit_jump_memop", ex_memop, 3'd0);
        check("lit_jump_we", ex_writeEnable, 1'b0);
        step(1'b1, mk(3'd0, 5'h02), 32'h8F0, 5'd6, 1'b1, 1'b0);
        check("lit_nopcls_alusel", ex_alusel, 3'd0);
        check("lit_nopcls_we", ex_writeEnable, 1'b0);
        idle(1'b1);

        // Mixed traffic with varying back-pressure and occasional flush
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom,
                 5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0));
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Parametrised ID/EX pipeline stage with a valid/ready handshake, a two-entry skid buffer, and a synchronous flush. It sits between decode and execute. It accepts one decoded instruction per cycle and splits the execute opcode into an ALU select, ALU sub-op, memory op and register write-enable for execute and the stages after it. It replaces the free-running ID/EX register so that execute back-pressure (multi-cycle ALU, memory wait) and branch flush are handled without losing or duplicating instructions.

## Interface
Parameters:
- WORD_W, 32, width of operand and offset words
- REG_ADDR_W, 5, register address width
- EX_OP_W, 8, full execute-opcode width
- EX_OP_HIGH_W, 3, opcode class field (upper bits); low field = EX_OP_W-EX_OP_HIGH_W

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  kill all held and incoming instructions this cycle
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage can accept (registered)
- id_exop  in  EX_OP_W  execute opcode
- id_srcl, id_srcr, id_offset  in  WORD_W  operands, offset
- id_dest  in  REG_ADDR_W  destination register
- ex_valid  out  1  output entry valid
- ex_ready  in  1  execute consumes the entry
- ex_alusel  out  3  ALU unit select
- ex_aluop  out  EX_OP_W-EX_OP_HIGH_W  ALU sub-op
- ex_srcl, ex_srcr, ex_offset  out  WORD_W  operands, offset
- ex_memop  out  3  memory-stage op
- ex_dest  out  REG_ADDR_W  destination
- ex_writeEnable  out  1  register write-back enable

## Operation
- Transfers: an input transfer happens on id_valid&&id_ready. An output transfer happens on ex_valid&&ex_ready.
- Storage: a main entry drives the outputs. A skid entry captures an input that arrives when the main entry is held.
- id_ready = !skid_valid. It is a flop output with no combinational path from ex_ready.
- Decode happens at input capture. Entries store the decoded fields, not the raw opcode.
- Decode by class (upper opcode bits):
  - LOGIC, SHIFT, ARITH, MOVE: alusel = the matching unit; memop WRITE_REG; writeEnable 1.
  - LOAD: alusel ARITH (address add); memop LOAD; writeEnable 1.
  - STORE: alusel ARITH; memop STORE; writeEnable 0.
  - JUMP: alusel NOP; memop NOP; writeEnable 0.
  - Unknown class: alusel NOP; memop NOP; writeEnable 0.
- writeEnable is forced to 0 whenever dest == 0.
- aluop is always the low opcode field, copied through.
- When ex_valid=0, the outputs show a bubble: alusel NOP, memop NOP, writeEnable 0. Data fields and dest keep their last loaded values.
- Flush:
  - Clears main_valid and skid_valid next cycle.
  - The input offered in the flush cycle is dropped, even if id_ready=1.
  - Flush has priority over every transfer. A same-cycle output transfer still counts as consumed.
- Reset:
  - Every output goes to 0: ex_alusel NOP(0), ex_aluop 0, operands 0, ex_memop NOP(0), ex_dest 0, ex_writeEnable 0, ex_valid 0.
  - id_ready=1.
  - Reset mid-stream discards both entries.

## Timing
- Latency is 1 cycle from input transfer to ex_valid. Throughput is 1 per cycle while ex_ready=1.
- Main entry is empty, or emptied this cycle: the input loads into the main entry.
- Main entry is held (ex_valid&&!ex_ready) and an input transfer occurs: the input goes to the skid entry. id_ready drops next cycle.
- Skid entry is full and the main entry is consumed: skid moves to main next cycle. id_ready returns to 1 in that same next cycle.
- Stall and release never lose or reorder entries. A stalled entry's outputs stay stable until consumed.

## Structure
- Shared package `ex_defs`:
  - Class codes: NOP, LOGIC, SHIFT, ARITH, MOVE, LOAD, STORE, JUMP.
  - ALU select codes: NOP, LOGIC, SHIFT, ARITH, MOVE.
  - Mem op codes: NOP, WRITE_REG, LOAD, STORE.
  - Decoded-entry struct type.
- Sub-module `ex_op_decode`: combinational class→{alusel, memop, writeEnable}, including the dest==0 masking. The top module holds the two entries and the handshake.

## Test plan
- Reset, then LOGIC op (exop class LOGIC, low 0x05, srcl 0x1234, dest 3) with ex_ready=1 → next cycle: ex_valid=1, alusel LOGIC, aluop 0x05, memop WRITE_REG, writeEnable=1, ex_srcl=0x1234.
- Back-to-back stream of 4 ops; ex_ready=0 for 3 cycles starting at op 2 → id_ready falls one cycle after the skid fills; all 4 ops appear in order, none dropped or duplicated; outputs hold stable during the stall.
- STORE to dest 7, then ARITH to dest 0 → STORE shows writeEnable=0, memop STORE; ARITH shows writeEnable=0 (zero-dest mask).
- Skid full plus flush with id_valid=1 → next cycle: ex_valid=0, id_ready=1, outputs show a bubble; the flushed-cycle input never appears.
- Assert rst while both entries are valid → next cycle: all outputs at reset values, id_ready=1.
- Unknown class code (e.g. 3'b111 if unassigned) → alusel NOP, memop NOP, writeEnable=0, ex_valid=1.
